bin_search_initiator: RTL and testbench

- Sequential initiator that sits on the operand side of a magnitude comparator.
- Drives a trial operand (guess) into an external comparator whose other input holds an unknown target value.
- Consumes the comparator's Equal/Greater/Smaller result and binary-searches the range 0..2^WIDTH-1 until Equal is reported.
- Reports the found value, the probe count, and an error if the feedback is inconsistent.

---
 rtl/bin_search_initiator.sv | 119 +++++++++++
 tb/tb_bin_search_initiator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bin_search_initiator.sv
// Binary-search initiator that drives trial operands into an external magnitude comparator.
// Optional macro BIN_SEARCH_ONEHOT_CHECK_EN: reject any comparator result that is not one-hot.
module bin_search_initiator #(
    parameter int WIDTH = 3,
    localparam int SW = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_smaller,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] found,
    output logic [SW-1:0]    step_count
);

    typedef enum logic [2:0] {IDLE, PROBE, CHECK, DONE, ERR} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] low, low_n, high, high_n, guess_n, found_n;
    logic [SW-1:0]    step_n;
    logic [WIDTH:0]   sum;
    logic             bad_result;

    // One extra bit keeps low+high from wrapping when high is all ones.
    assign sum = {1'b0, low} + {1'b0, high};

`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
    assign bad_result = !$onehot({cmp_equal, cmp_greater, cmp_smaller});
`else
    assign bad_result = !(cmp_equal || cmp_greater || cmp_smaller);
`endif

    always_comb begin
        state_n = state;
        low_n   = low;
        high_n  = high;
        guess_n = guess;
        found_n = found;
        step_n  = step_count;
        case (state)
            IDLE: begin
                if (start) begin
                    low_n   = '0;
                    high_n  = '1;
                    step_n  = '0;
                    found_n = '0;
                    state_n = PROBE;
                end
            end
            PROBE: begin
                guess_n = sum[WIDTH:1];
                step_n  = step_count + SW'(1);
                state_n = CHECK;
            end
            CHECK: begin
                if (bad_result) begin
                    state_n = ERR;
                end else if (cmp_equal) begin
                    found_n = guess;
                    state_n = DONE;
                end else if (cmp_greater) begin
                    if (guess == high) begin
                        state_n = ERR;
                    end else begin
                        low_n   = guess + WIDTH'(1);
                        state_n = PROBE;
                    end
                end else begin
                    if (guess == low) begin
                        state_n = ERR;
                    end else begin
                        high_n  = guess - WIDTH'(1);
                        state_n = PROBE;
                    end
                end
                if (state_n == ERR) begin
                    found_n = '0;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs are registered copies of what the next state implies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            low         <= '0;
            high        <= '0;
            guess       <= '0;
            found       <= '0;
            step_count  <= '0;
            guess_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            low         <= low_n;
            high        <= high_n;
            guess       <= guess_n;
            found       <= found_n;
            step_count  <= step_n;
            guess_valid <= (state_n == CHECK);
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
            err         <= (state_n == ERR);
        end
    end

endmodule

// File: tb/tb_bin_search_initiator.sv
// Self-checking bench for bin_search_initiator: table of searches plus reset and busy-start corner cases.
module tb_bin_search_initiator;

    localparam int WIDTH = 3;
    localparam int SW    = $clog2(WIDTH + 2);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             cmp_equal, cmp_greater, cmp_smaller;
    logic [WIDTH-1:0] guess;
    logic             guess_valid, busy, done, err;
    logic [WIDTH-1:0] found;
    logic [SW-1:0]    step_count;

    int               target = 0;
    int               mode = 0; // 0 ideal, 1 always smaller, 2 greater+smaller at first probe, 3 no result
    int               pass_cnt = 0;
    int               total_cnt = 0;
    int               exp_q[$];

    bin_search_initiator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmp_equal(cmp_equal), .cmp_greater(cmp_greater), .cmp_smaller(cmp_smaller),
        .guess(guess), .guess_valid(guess_valid), .busy(busy), .done(done), .err(err),
        .found(found), .step_count(step_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        cmp_equal   = (int'(guess) == target);
        cmp_greater = (target > int'(guess));
        cmp_smaller = (target < int'(guess));
        case (mode)
            1: begin cmp_equal = 1'b0; cmp_greater = 1'b0; cmp_smaller = 1'b1; end
            2: if (step_count == SW'(1)) begin
                   cmp_equal = 1'b0; cmp_greater = 1'b1; cmp_smaller = 1'b1;
               end
            3: begin cmp_equal = 1'b0; cmp_greater = 1'b0; cmp_smaller = 1'b0; end
            default: ;
        endcase
    end

    typedef struct {
        string name;
        int    mode;
        int    target;
        bit    start_mid;
        int    n_guess;
        int    g[4];
        int    exp_found;
        int    exp_steps;
        bit    exp_err;
        int    exp_cycles;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic run_search(input vec_t v);
        int cyc;
        bit term;
        mode   = v.mode;
        target = v.target;
        for (int i = 0; i < v.n_guess; i++) exp_q.push_back(v.g[i]);
        start = 1'b1;
        cyc  = 0;
        term = 1'b0;
        while (!term && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (v.start_mid && cyc == 2);
            if (guess_valid) begin
                if (exp_q.size() == 0) check({v.name, " extra guess"}, int'(guess), -1);
                else check({v.name, " guess"}, int'(guess), exp_q.pop_front());
            end
            if (done || err) term = 1'b1;
        end
        start = 1'b0;
        check({v.name, " terminated"}, int'(term), 1);
        check({v.name, " cycles"}, cyc, v.exp_cycles);
        check({v.name, " done"}, int'(done), int'(!v.exp_err));
        check({v.name, " err"}, int'(err), int'(v.exp_err));
        check({v.name, " found"}, int'(found), v.exp_found);
        check({v.name, " step_count"}, int'(step_count), v.exp_steps);
        check({v.name, " leftover guesses"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check({v.name, " busy after"}, int'(busy), 0);
        check({v.name, " pulse cleared"}, int'(done || err), 0);
        check({v.name, " found held"}, int'(found), v.exp_found);
    endtask

    initial begin
        int   n;
        vec_t v;
        vecs.push_back('{"t5",       0, 5, 1'b0, 2, '{3, 5, 0, 0}, 5, 2, 1'b0, 5});
        vecs.push_back('{"t0",       0, 0, 1'b0, 3, '{3, 1, 0, 0}, 0, 3, 1'b0, 7});
        vecs.push_back('{"t7",       0, 7, 1'b0, 4, '{3, 5, 6, 7}, 7, 4, 1'b0, 9});
        vecs.push_back('{"t2",       0, 2, 1'b0, 3, '{3, 1, 2, 0}, 2, 3, 1'b0, 7});
        vecs.push_back('{"smaller",  1, 4, 1'b0, 3, '{3, 1, 0, 0}, 0, 3, 1'b1, 7});
        vecs.push_back('{"noresult", 3, 4, 1'b0, 1, '{3, 0, 0, 0}, 0, 1, 1'b1, 3});
        vecs.push_back('{"t5busy",   0, 5, 1'b1, 2, '{3, 5, 0, 0}, 5, 2, 1'b0, 5});
`ifdef BIN_SEARCH_ONEHOT_CHECK_EN
        vecs.push_back('{"twohot",   2, 2, 1'b0, 1, '{3, 0, 0, 0}, 0, 1, 1'b1, 3});
`else
        vecs.push_back('{"twohot",   2, 2, 1'b0, 3, '{3, 5, 4, 0}, 0, 3, 1'b1, 7});
`endif

        @(negedge clk);
        check("reset outputs", int'({guess, guess_valid, busy, done, err, found, step_count}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", int'(busy), 0);

        foreach (vecs[i]) run_search(vecs[i]);

        // Reset during the second CHECK of a target=5 search, then a clean rerun.
        mode = 0; target = 5;
        exp_q.push_back(3); exp_q.push_back(5);
        start = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (guess_valid) begin
                n++;
                if (exp_q.size() == 0) check("rst guess extra", int'(guess), -1);
                else check("rst guess", int'(guess), exp_q.pop_front());
            end
        end
        check("rst reached second check", n, 2);
        reset = 1'b1;
        #1;
        check("rst mid outputs", int'({guess, guess_valid, busy, done, err, found, step_count}), 0);
        @(negedge clk);
        check("rst held no pulse", int'({done, err, busy}), 0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        v = vecs[0];
        v.name = "after rst";
        run_search(v);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
